// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register-file write port between pipeline WB and the long mul/div unit, and tracks pending long writes.
// Latency: the write mux is combinational (0 cycles); a blocked long result is granted at most MAX_WAIT cycles after it is first presented.
// Backpressure: the pipe always wins the port except in DRAIN; the long unit holds LongValid until LongReady; DRAIN raises StallPipe for one cycle.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PipeWrEn,
  input  logic [4:0]  PipeRW,
  input  logic [31:0] PipeBusW,
  input  logic        LongValid,
  input  logic [4:0]  LongRW,
  input  logic [31:0] LongBusW,
  output logic        LongReady,
  input  logic        IssueLong,
  input  logic [4:0]  IssueRd,
  input  logic [4:0]  RA_Chk,
  input  logic [4:0]  RB_Chk,
  output logic        RABusy,
  output logic        RBBusy,
  output logic        RegWr,
  output logic [4:0]  RW,
  output logic [31:0] BusW,
  output logic        StallPipe,
  output logic [31:0] Pending,
  output logic        ProtoErr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pending_q, pending_d;
  logic             err_q, err_d;

  logic             pipe_block;
  logic             long_acc;
  logic             issue_set;
  logic             fsm_err;
  logic             sb_err;
  logic [31:0]      set_vec;
  logic [31:0]      clr_vec;

  // A pipe write to R0 is a no-op and never occupies the port.
  assign pipe_block = PipeWrEn & (PipeRW != 5'd0);
  assign LongReady  = (state_q == S_DRAIN) | ~pipe_block;
  assign long_acc   = LongValid & LongReady;
  assign StallPipe  = (state_q == S_DRAIN);
  assign Pending    = pending_q;
  assign ProtoErr   = err_q;
  assign RABusy     = pending_q[RA_Chk];
  assign RBBusy     = pending_q[RB_Chk];

  // Write-port mux: pipe has priority unless the long unit is being drained.
  always_comb begin
    RegWr = 1'b0;
    RW    = 5'd0;
    BusW  = 32'd0;
    if (pipe_block && (state_q != S_DRAIN)) begin
      RegWr = 1'b1;
      RW    = PipeRW;
      BusW  = PipeBusW;
    end else if (long_acc) begin
      RegWr = 1'b1;
      RW    = LongRW;
      BusW  = LongBusW;
    end
  end

  // Arbitration FSM: count blocked cycles and force a drain before starvation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fsm_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (LongValid && !LongReady) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (long_acc) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!LongValid) begin
          // Valid dropped before acceptance: handshake violation.
          state_d = S_IDLE;
          cnt_d   = '0;
          fsm_err = 1'b1;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // Long unit owns the port this cycle; a pipe write here is lost.
        state_d = S_IDLE;
        cnt_d   = '0;
        if (!LongValid || pipe_block) begin
          fsm_err = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Scoreboard update and protocol checks; a set beats a same-cycle clear.
  always_comb begin
    issue_set = IssueLong & (IssueRd != 5'd0);
    set_vec   = issue_set ? (32'd1 << IssueRd) : 32'd0;
    clr_vec   = long_acc ? (32'd1 << LongRW) : 32'd0;
    pending_d = ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
    sb_err    = 1'b0;
    if (issue_set && pending_q[IssueRd] && !(long_acc && (LongRW == IssueRd))) begin
      sb_err = 1'b1;
    end
    if (pipe_block && pending_q[PipeRW]) begin
      sb_err = 1'b1;
    end
    if (long_acc && (LongRW != 5'd0) && !pending_q[LongRW]) begin
      sb_err = 1'b1;
    end
    err_d = err_q | sb_err | fsm_err;
  end

  // State registers; reset aborts any in-flight wait or drain.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pending_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        Clk;
  logic        Reset;
  logic        PipeWrEn;
  logic [4:0]  PipeRW;
  logic [31:0] PipeBusW;
  logic        LongValid;
  logic [4:0]  LongRW;
  logic [31:0] LongBusW;
  logic        LongReady;
  logic        IssueLong;
  logic [4:0]  IssueRd;
  logic [4:0]  RA_Chk;
  logic [4:0]  RB_Chk;
  logic        RABusy;
  logic        RBBusy;
  logic        RegWr;
  logic [4:0]  RW;
  logic [31:0] BusW;
  logic        StallPipe;
  logic [31:0] Pending;
  logic        ProtoErr;

  int checks   = 0;
  int failures = 0;
  bit sb_en    = 1'b0;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .PipeWrEn(PipeWrEn), .PipeRW(PipeRW), .PipeBusW(PipeBusW),
    .LongValid(LongValid), .LongRW(LongRW), .LongBusW(LongBusW),
    .LongReady(LongReady),
    .IssueLong(IssueLong), .IssueRd(IssueRd),
    .RA_Chk(RA_Chk), .RB_Chk(RB_Chk), .RABusy(RABusy), .RBBusy(RBBusy),
    .RegWr(RegWr), .RW(RW), .BusW(BusW),
    .StallPipe(StallPipe), .Pending(Pending), .ProtoErr(ProtoErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every register-file write must match the next expected write in order.
  always @(negedge Clk) begin
    if (sb_en && RegWr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_write observed RW=%0d BusW=0x%0h expected no write", RW, BusW);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wr_RW", {27'd0, RW}, {27'd0, e[36:32]});
        chk("wr_BusW", BusW, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    @(negedge Clk);
  endtask

  task automatic push_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic idle_inputs();
    PipeWrEn  = 1'b0; PipeRW = 5'd0; PipeBusW = 32'd0;
    LongValid = 1'b0; LongRW = 5'd0; LongBusW = 32'd0;
    IssueLong = 1'b0; IssueRd = 5'd0;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle_inputs();
    IssueLong = 1'b1;
    IssueRd   = rd;
    settle();
    tick();
    idle_inputs();
  endtask

  task automatic pulse_reset();
    idle_inputs();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    settle();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    RA_Chk = 5'd0;
    RB_Chk = 5'd0;
    idle_inputs();
    tick();
    tick();
    settle();
    chk("rst_Pending", Pending, 32'd0);
    chk("rst_StallPipe", {31'd0, StallPipe}, 32'd0);
    chk("rst_ProtoErr", {31'd0, ProtoErr}, 32'd0);
    chk("rst_LongReady", {31'd0, LongReady}, 32'd1);
    chk("rst_RegWr", {31'd0, RegWr}, 32'd0);
    Reset = 1'b0;
    sb_en = 1'b1;
    tick();

    // Issue to R5, then commit it with no pipe contention.
    issue(5'd5);
    RA_Chk = 5'd5;
    settle();
    chk("t1_Pending_set", Pending, 32'h20);
    chk("t1_RABusy", {31'd0, RABusy}, 32'd1);
    chk("t1_RBBusy", {31'd0, RBBusy}, 32'd0);
    tick();
    LongValid = 1'b1; LongRW = 5'd5; LongBusW = 32'hDEADBEEF;
    push_wr(5'd5, 32'hDEADBEEF);
    settle();
    chk("t1_RegWr", {31'd0, RegWr}, 32'd1);
    chk("t1_LongReady", {31'd0, LongReady}, 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("t1_Pending_clr", Pending, 32'd0);
    chk("t1_RABusy_clr", {31'd0, RABusy}, 32'd0);
    tick();

    // Pipe and long collide: pipe first, long the next cycle.
    issue(5'd7);
    PipeWrEn = 1'b1; PipeRW = 5'd3; PipeBusW = 32'h33;
    LongValid = 1'b1; LongRW = 5'd7; LongBusW = 32'h77;
    push_wr(5'd3, 32'h33);
    settle();
    chk("t2_LongReady_blocked", {31'd0, LongReady}, 32'd0);
    tick();
    PipeWrEn = 1'b0;
    push_wr(5'd7, 32'h77);
    settle();
    chk("t2_LongReady_free", {31'd0, LongReady}, 32'd1);
    chk("t2_StallPipe", {31'd0, StallPipe}, 32'd0);
    tick();
    idle_inputs();
    settle();
    chk("t2_Pending", Pending, 32'd0);
    chk("t2_ProtoErr", {31'd0, ProtoErr}, 32'd0);
    tick();

    // Pipe write to R0 does not block the long unit.
    issue(5'd9);
    PipeWrEn = 1'b1; PipeRW = 5'd0; PipeBusW = 32'h99;
    LongValid = 1'b1; LongRW = 5'd9; LongBusW = 32'h99999999;
    push_wr(5'd9, 32'h99999999);
    settle();
    chk("t3_LongReady", {31'd0, LongReady}, 32'd1);
    chk("t3_StallPipe", {31'd0, StallPipe}, 32'd0);
    tick();
    idle_inputs();

    // Continuous pipe blocking forces a drain in cycle 4; pipe honours bubble.
    issue(5'd12);
    for (int c = 0; c < 4; c++) begin
      PipeWrEn = 1'b1; PipeRW = 5'd1; PipeBusW = 32'h100 + 32'(c);
      LongValid = 1'b1; LongRW = 5'd12; LongBusW = 32'hC0C0;
      push_wr(5'd1, 32'h100 + 32'(c));
      settle();
      chk($sformatf("t4_stall_c%0d", c), {31'd0, StallPipe}, 32'd0);
      chk($sformatf("t4_ready_c%0d", c), {31'd0, LongReady}, 32'd0);
      tick();
    end
    PipeWrEn = 1'b0;
    push_wr(5'd12, 32'hC0C0);
    settle();
    chk("t4_stall_c4", {31'd0, StallPipe}, 32'd1);
    chk("t4_ready_c4", {31'd0, LongReady}, 32'd1);
    chk("t4_regwr_c4", {31'd0, RegWr}, 32'd1);
    tick();
    LongValid = 1'b0;
    PipeWrEn = 1'b1; PipeRW = 5'd1; PipeBusW = 32'h1FF;
    push_wr(5'd1, 32'h1FF);
    settle();
    chk("t4_stall_c5", {31'd0, StallPipe}, 32'd0);
    chk("t4_ProtoErr", {31'd0, ProtoErr}, 32'd0);
    chk("t4_Pending", Pending, 32'd0);
    tick();
    idle_inputs();

    // Issue and commit of the same register in one cycle: set wins, no error.
    issue(5'd4);
    IssueLong = 1'b1; IssueRd = 5'd4;
    LongValid = 1'b1; LongRW = 5'd4; LongBusW = 32'h44;
    push_wr(5'd4, 32'h44);
    settle();
    chk("t5_RegWr", {31'd0, RegWr}, 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("t5_Pending_kept", Pending, 32'h10);
    chk("t5_ProtoErr_clean", {31'd0, ProtoErr}, 32'd0);
    tick();
    issue(5'd4);
    settle();
    chk("t5_ProtoErr_waw", {31'd0, ProtoErr}, 32'd1);
    chk("t5_Pending_waw", Pending, 32'h10);
    tick();
    pulse_reset();
    settle();
    chk("t5_rst_ProtoErr", {31'd0, ProtoErr}, 32'd0);
    chk("t5_rst_Pending", Pending, 32'd0);
    tick();

    // Pipe ignores the drain bubble: write lost, long proceeds, error flagged.
    issue(5'd13);
    for (int c = 0; c < 4; c++) begin
      PipeWrEn = 1'b1; PipeRW = 5'd2; PipeBusW = 32'h200 + 32'(c);
      LongValid = 1'b1; LongRW = 5'd13; LongBusW = 32'hD13;
      push_wr(5'd2, 32'h200 + 32'(c));
      settle();
      tick();
    end
    PipeBusW = 32'h222;
    push_wr(5'd13, 32'hD13);
    settle();
    chk("t6_stall_drain", {31'd0, StallPipe}, 32'd1);
    chk("t6_ready_drain", {31'd0, LongReady}, 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("t6_ProtoErr", {31'd0, ProtoErr}, 32'd1);
    chk("t6_stall_after", {31'd0, StallPipe}, 32'd0);
    chk("t6_Pending", Pending, 32'd0);
    tick();
    pulse_reset();

    // Async reset while in WAIT with counter=2 and an error already latched.
    issue(5'd14);
    PipeWrEn = 1'b1; PipeRW = 5'd2; PipeBusW = 32'h2A;
    LongValid = 1'b1; LongRW = 5'd14; LongBusW = 32'hE14;
    push_wr(5'd2, 32'h2A);
    settle();
    tick();
    PipeRW = 5'd14; PipeBusW = 32'h2B;
    push_wr(5'd14, 32'h2B);
    settle();
    tick();
    chk("t7_pre_Pending", Pending, 32'h4000);
    chk("t7_pre_ProtoErr", {31'd0, ProtoErr}, 32'd1);
    idle_inputs();
    #2;
    Reset = 1'b1;
    #1;
    chk("t7_async_Pending", Pending, 32'd0);
    chk("t7_async_StallPipe", {31'd0, StallPipe}, 32'd0);
    chk("t7_async_ProtoErr", {31'd0, ProtoErr}, 32'd0);
    settle();
    Reset = 1'b0;
    tick();

    settle();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Owns the single write port (RW/BusW/RegWr) of the 32x32 register file. It shares that port between the main pipeline writeback stage and the long-latency multiply/divide unit, which uses a valid/ready handshake. It keeps a 32-bit pending-write scoreboard so hazard logic can stall readers of registers the long unit has not yet written. A bounded-wait counter forces a pipeline bubble so the long unit is never starved.

Parameters:
MAX_WAIT, 4, max consecutive blocked cycles for a valid long-unit request before the arbiter forces a drain (legal range 2..7)
CNT_W, 3, width of the wait counter; must hold MAX_WAIT

Ports:
Clk  in  1  clock; all state updates on posedge
Reset  in  1  asynchronous, active-high reset
PipeWrEn  in  1  pipeline writeback request; cannot be back-pressured
PipeRW  in  5  pipeline destination register
PipeBusW  in  32  pipeline write data
LongValid  in  1  long unit has a result; must hold with data stable until accepted
LongRW  in  5  long unit destination register
LongBusW  in  32  long unit write data
LongReady  out  1  long write accepted this cycle when LongValid&LongReady
IssueLong  in  1  a long op issues this cycle
IssueRd  in  5  destination of the issuing long op
RA_Chk  in  5  source register A to check
RB_Chk  in  5  source register B to check
RABusy  out  1  RA_Chk has a pending long write
RBBusy  out  1  RB_Chk has a pending long write
RegWr  out  1  to register file write enable
RW  out  5  to register file write address
BusW  out  32  to register file write data
StallPipe  out  1  pipeline must insert a WB bubble this cycle
Pending  out  32  scoreboard bits (bit 0 always 0)
ProtoErr  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async): Pending=0, state=IDLE, counter=0, ProtoErr=0. Hence StallPipe=0. Combinational outputs follow inputs.
- PipeBlock = PipeWrEn & (PipeRW!=0). A pipe write to R0 does not occupy the port.
- Write mux (combinational, zero latency): if PipeBlock and state!=DRAIN, then RegWr=1, RW=PipeRW, BusW=PipeBusW. Else if LongValid&LongReady, then RegWr=1, RW=LongRW, BusW=LongBusW. Else RegWr=0, RW=0, BusW=0.
- LongReady = (state==DRAIN) | ~PipeBlock.
- FSM states: IDLE, WAIT, DRAIN. StallPipe = (state==DRAIN), so it is registered.
  - IDLE: if LongValid & ~LongReady, go to WAIT with counter=1. Otherwise stay.
  - WAIT:
    - If LongValid & LongReady, go to IDLE with counter=0.
    - Else if ~LongValid (valid dropped), go to IDLE and set ProtoErr.
    - Else if counter==MAX_WAIT-1, go to DRAIN.
    - Else increment counter.
  - DRAIN: the long unit wins the port unconditionally.
    - If LongValid, grant, then go to IDLE with counter=0.
    - If ~LongValid, set ProtoErr and go to IDLE.
    - If PipeBlock is also asserted, set ProtoErr; the pipe write is lost and the long write proceeds.
- Worst-case latency: a long result blocked every cycle is accepted in cycle MAX_WAIT after first presentation.
- Scoreboard:
  - Set Pending[IssueRd] when IssueLong & IssueRd!=0.
  - Clear Pending[LongRW] on long acceptance.
  - Simultaneous set and clear of the same register: set wins.
  - Issue to a register already pending (and not being cleared in the same cycle): set ProtoErr (WAW).
  - Pipe write (PipeBlock) to a pending register: set ProtoErr.
  - Long acceptance with Pending[LongRW]=0 and LongRW!=0: set ProtoErr.
- RABusy = Pending[RA_Chk]; RBBusy = Pending[RB_Chk]. Bit 0 is never set, so R0 is never busy.
- Busy clears the cycle after commit, which matches the register file write landing at the same edge.
- ProtoErr clears only on Reset.
- Reset mid-WAIT or mid-DRAIN aborts the grant. The long unit is reset together with this block.

Test Plan:
- Reset, then IssueLong Rd=5. Next cycle Pending=0x20 and RA_Chk=5 gives RABusy=1. LongValid RW=5 data 0xDEADBEEF, no pipe write, gives same-cycle RegWr=1, RW=5, BusW=0xDEADBEEF, and Pending=0 the following cycle.
- PipeWrEn RW=3 and LongValid RW=7 in the same cycle: RegWr writes R3 and LongReady=0. Pipe idle next cycle: long granted, RW=7, state returns to IDLE.
- PipeWrEn RW=0 and LongValid RW=9: LongReady=1 and R9 is written with no stall.
- Pipe blocks continuously with MAX_WAIT=4: WAIT for cycles 1-3, StallPipe=1 in cycle 4 with long granted, StallPipe=0 in cycle 5. ProtoErr stays 0 if the pipe honours the bubble. A pipe write during DRAIN sets ProtoErr=1.
- IssueLong Rd=4 in the same cycle as long commit RW=4 (pending): Pending[4] remains 1 and ProtoErr=0. A second IssueLong Rd=4 before commit gives ProtoErr=1.
- Assert Reset asynchronously while in WAIT with counter=2: StallPipe=0, Pending=0, ProtoErr=0 immediately, without waiting for a clock edge.
